add_round_key_stream: RTL and testbench

- Streaming, parametrised add-round-key stage for the AES datapath.
- Holds a loadable table of NR+1 128-bit round keys.
- Accepts state blocks W bits per beat over a valid/ready handshake and XORs each beat with the matching slice of the current round's key.
- Sequences round order automatically: ascending for encrypt, descending for decrypt. Sits between the round-function stages and the key-expansion block.

---
 rtl/add_round_key_stream.sv | 214 +++++++++++++++++++++
 tb/tb_add_round_key_stream.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_round_key_stream.sv
// -----------------------------------------------------------------------------
// add_round_key_stream
//   Streaming AES add-round-key stage. Holds a table of NR+1 128-bit round keys
//   and XORs each W-bit state beat with the matching slice of the current
//   round's key. Round order is sequenced automatically: ascending for encrypt,
//   descending for decrypt. One register stage on the output, full throughput.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   key_we/waddr/wdata    round-key table write (honoured only when idle)
//   start, decrypt        begin a pass of NR+1 blocks; decrypt picks direction
//   in_valid/ready/data   input beat handshake (W bits, MSB-first beats)
//   out_valid/ready/data  output beat handshake
//   out_last              final beat of a block
//   out_round             round index whose key was applied to this beat
//   busy                  a pass is in progress
//   done                  one-cycle pulse after the final beat is handed off
// -----------------------------------------------------------------------------
module add_round_key_stream #(
    parameter int unsigned W  = 32,
    parameter int unsigned NR = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           key_we,
    input  logic [3:0]     key_waddr,
    input  logic [127:0]   key_wdata,
    input  logic           start,
    input  logic           decrypt,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic [3:0]     out_round,
    output logic           busy,
    output logic           done
);

    localparam int unsigned BEATS = 128 / W;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [3:0]    NR4       = 4'(NR);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    // Reject unsupported builds at elaboration time.
    if (!(W == 8 || W == 16 || W == 32 || W == 64 || W == 128) ||
        !(NR == 10 || NR == 12 || NR == 14)) begin : g_param_check
        $error("add_round_key_stream: unsupported W=%0d / NR=%0d", W, NR);
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            dir_q, dir_d;
    logic [3:0]      round_q, round_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic [3:0]      out_round_q, out_round_d;
    logic            done_q, done_d;
    logic [127:0]    key_q [NR+1];
    logic [127:0]    key_d [NR+1];

    logic                     in_ready_c;
    logic                     accept_c;
    logic                     handoff_c;
    logic                     final_round_c;
    logic [127:0]             cur_key_c;
    logic [BEATS-1:0][W-1:0]  key_beats_c;
    logic [W-1:0]             key_slice_c;

    // Handshake qualifiers: input accepted only while running and the output
    // register is empty or being drained this cycle.
    always_comb begin
        in_ready_c    = (state_q == RUN) && (!out_valid_q || out_ready);
        accept_c      = in_valid && in_ready_c;
        handoff_c     = out_valid_q && out_ready;
        final_round_c = dir_q ? (round_q == 4'd0) : (round_q == NR4);
    end

    // Current round key; round never exceeds NR so a one-hot compare suffices.
    always_comb begin
        cur_key_c = '0;
        for (int unsigned i = 0; i <= NR; i++) begin
            if (round_q == 4'(i)) begin
                cur_key_c = key_q[i];
            end
        end
    end

    // Beat 0 is the most significant W bits of the key (FIPS byte order).
    always_comb begin
        key_beats_c = cur_key_c;
        key_slice_c = key_beats_c[LAST_BEAT - beat_q];
    end

    // Key table writes, only while idle and only to valid indices.
    always_comb begin
        key_d = key_q;
        if ((state_q == IDLE) && key_we && (key_waddr <= NR4)) begin
            for (int unsigned i = 0; i <= NR; i++) begin
                if (key_waddr == 4'(i)) begin
                    key_d[i] = key_wdata;
                end
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        round_d     = round_q;
        beat_d      = beat_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_round_d = out_round_q;
        done_d      = 1'b0;

        // Output register: load on accept, otherwise empty on handoff.
        if (accept_c) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data ^ key_slice_c;
            out_last_d  = (beat_q == LAST_BEAT);
            out_round_d = round_q;
        end else if (handoff_c) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    dir_d   = decrypt;
                    round_d = decrypt ? NR4 : 4'd0;
                    beat_d  = '0;
                end
            end
            RUN: begin
                if (accept_c) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        // Termination is checked before stepping so the
                        // counter never leaves 0..NR.
                        if (final_round_c) begin
                            state_d = DRAIN;
                        end else begin
                            round_d = dir_q ? (round_q - 4'd1) : (round_q + 4'd1);
                        end
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            DRAIN: begin
                if (handoff_c) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dir_q       <= 1'b0;
            round_q     <= '0;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_round_q <= '0;
            done_q      <= 1'b0;
            for (int unsigned i = 0; i <= NR; i++) begin
                key_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            round_q     <= round_d;
            beat_q      <= beat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_round_q <= out_round_d;
            done_q      <= done_d;
            for (int unsigned i = 0; i <= NR; i++) begin
                key_q[i] <= key_d[i];
            end
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_round = out_round_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_add_round_key_stream.sv
// -----------------------------------------------------------------------------
// tb_add_round_key_stream
//   Directed bench for add_round_key_stream. A W=32 instance carries most of the
//   sequence; a W=128 instance sharing clock, reset and key-write ports checks
//   the one-beat-per-block build. Expected beats are queued when a beat is
//   accepted and compared when the DUT hands the beat off.
// -----------------------------------------------------------------------------
module tb_add_round_key_stream;

    localparam int unsigned W  = 32;
    localparam int unsigned NR = 10;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
        logic [3:0]   round;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           key_we;
    logic [3:0]     key_waddr;
    logic [127:0]   key_wdata;
    logic           start, decrypt;
    logic           in_valid, in_ready;
    logic [W-1:0]   in_data;
    logic           out_valid, out_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [3:0]     out_round;
    logic           busy, done;

    logic           start_b;
    logic           in_valid_b, in_ready_b;
    logic [127:0]   in_data_b;
    logic           out_valid_b, out_ready_b;
    logic [127:0]   out_data_b;
    logic           out_last_b;
    logic [3:0]     out_round_b;
    logic           busy_b, done_b;

    exp_t           sb_q[$];
    exp_t           sb_b[$];
    logic [127:0]   keys [NR+1];
    logic [31:0]    pass_in  [44];
    logic [31:0]    pass_exp [44];
    int             n_tests = 0;
    int             n_fail  = 0;

    always #5 clk = ~clk;

    add_round_key_stream #(.W(W), .NR(NR)) u_dut (
        .clk(clk), .reset(reset),
        .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
        .start(start), .decrypt(decrypt),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_round(out_round),
        .busy(busy), .done(done)
    );

    add_round_key_stream #(.W(128), .NR(NR)) u_dut128 (
        .clk(clk), .reset(reset),
        .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
        .start(start_b), .decrypt(decrypt),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_last(out_last_b), .out_round(out_round_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboards: compare at mid-cycle whenever a beat is being handed off.
    // An empty queue yields round 15, which no legal beat can carry.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
            check("out_beat_w32", 160'({128'(out_data), out_last, out_round}), 160'(e));
        end
        if (!reset && out_valid_b && out_ready_b) begin
            e = (sb_b.size() > 0) ? sb_b.pop_front() : '1;
            check("out_beat_w128", 160'({out_data_b, out_last_b, out_round_b}), 160'(e));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [3:0] a, input logic [127:0] d);
        key_we    = 1'b1;
        key_waddr = a;
        key_wdata = d;
        tick();
        key_we    = 1'b0;
        if (a <= 4'(NR)) keys[a] = d;
    endtask

    task automatic load_pattern();
        for (int i = 0; i <= int'(NR); i++) load_key(4'(i), {32{4'(i)}});
    endtask

    // Present one beat until accepted; queue its expectation at the accept.
    task automatic drive(input logic [31:0] d, input logic [31:0] e,
                         input logic last, input logic [3:0] rnd);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            #2;
            if (in_ready) begin
                sb_q.push_back('{data: 128'(e), last: last, round: rnd});
                ok = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout_w32", 160'(ok), 160'(1));
    endtask

    task automatic drive_b(input logic [127:0] d, input logic [127:0] e, input logic [3:0] rnd);
        logic ok;
        ok         = 1'b0;
        in_valid_b = 1'b1;
        in_data_b  = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            #2;
            if (in_ready_b) begin
                sb_b.push_back('{data: e, last: 1'b1, round: rnd});
                ok = 1'b1;
            end
            tick();
        end
        in_valid_b = 1'b0;
        if (!ok) check("accept_timeout_w128", 160'(ok), 160'(1));
    endtask

    // Expected beats from the bench's own key-table model.
    task automatic fill_exp(input logic dec);
        int r, b;
        for (int k = 0; k < 44; k++) begin
            r = dec ? int'(NR) - k / 4 : k / 4;
            b = k % 4;
            pass_exp[k] = pass_in[k] ^ keys[r][127 - b*32 -: 32];
        end
    endtask

    // mode 1: ignored key write / start mid-pass; mode 2: output backpressure.
    task automatic run_pass(input logic dec, input int nb, input int mode);
        int r;
        logic [W-1:0] held;
        start   = 1'b1;
        decrypt = dec;
        tick();
        start   = 1'b0;
        decrypt = 1'b0;
        check("busy_after_start", 160'(busy), 160'(1));
        for (int k = 0; k < nb; k++) begin
            r = dec ? int'(NR) - k / 4 : k / 4;
            if (mode == 1 && k == 4) begin
                key_we = 1'b1; key_waddr = 4'd3; key_wdata = '1;
                start  = 1'b1; decrypt = ~dec;
            end
            if (mode == 1 && k == 6) begin
                key_we = 1'b0; start = 1'b0; decrypt = 1'b0;
            end
            if (mode == 2 && k == 22) begin
                held      = out_data;
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = pass_in[k];
                for (int c = 0; c < 5; c++) begin
                    tick();
                    check("bp_hold", 160'({out_valid, out_data}), 160'({1'b1, held}));
                    check("bp_in_ready", 160'(in_ready), 160'(0));
                end
                out_ready = 1'b1;
            end
            drive(pass_in[k], pass_exp[k], (k % 4) == 3, 4'(r));
        end
        if (nb == 44) begin
            check("pre_done", 160'({busy, done}), 160'(2'b10));
            tick();
            check("done_pulse", 160'({busy, done, out_valid}), 160'(3'b010));
            tick();
            check("done_clear", 160'({busy, done}), 160'(2'b00));
            check("sb_drained", 160'(sb_q.size()), 160'(0));
        end
    endtask

    initial begin
        int waited;
        reset = 1'b1; key_we = 1'b0; key_waddr = '0; key_wdata = '0;
        start = 1'b0; decrypt = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        start_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
        for (int i = 0; i <= int'(NR); i++) keys[i] = '0;
        #12;
        check("reset_outputs", 160'({out_valid, out_data, out_last, out_round, busy, done, in_ready}), 160'(0));
        tick();
        reset = 1'b0;
        tick();
        check("idle_no_ready", 160'({in_ready, busy}), 160'(0));

        // Pattern table, FIPS-197 key in slot 0, out-of-range write ignored.
        load_pattern();
        load_key(4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        load_key(4'd12, '1);

        // Encrypt: FIPS App. B first block, then zero blocks; ignored events mid-pass.
        for (int k = 0; k < 44; k++) pass_in[k] = '0;
        pass_in[0] = 32'h3243f6a8; pass_in[1] = 32'h885a308d;
        pass_in[2] = 32'h313198a2; pass_in[3] = 32'he0370734;
        fill_exp(1'b0);
        pass_exp[0] = 32'h193de3be; pass_exp[1] = 32'ha0f4e22b;
        pass_exp[2] = 32'h9ac68d2a; pass_exp[3] = 32'he9f84808;
        run_pass(1'b0, 44, 1);

        // Decrypt with all-pattern table; backpressure mid-block.
        load_key(4'd0, '0);
        for (int k = 0; k < 44; k++) pass_in[k] = '0;
        fill_exp(1'b1);
        pass_exp[0] = 32'haaaaaaaa;
        run_pass(1'b1, 44, 2);

        // Reset during round 3 beat 2 aborts the pass and clears the table.
        for (int k = 0; k < 44; k++) pass_in[k] = $urandom;
        fill_exp(1'b0);
        run_pass(1'b0, 14, 0);
        in_valid = 1'b1;
        in_data  = pass_in[14];
        #2;
        reset = 1'b1;
        #1;
        check("abort_outputs", 160'({out_valid, out_data, out_last, out_round, busy, done, in_ready}), 160'(0));
        sb_q.delete();
        sb_b.delete();
        for (int i = 0; i <= int'(NR); i++) keys[i] = '0;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        fill_exp(1'b0);
        run_pass(1'b0, 8, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Reload and run a clean random-data encrypt pass.
        load_pattern();
        for (int k = 0; k < 44; k++) pass_in[k] = $urandom;
        fill_exp(1'b0);
        run_pass(1'b0, 44, 0);

        // W=128 build: one beat per block, out_last on every beat.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int r = 0; r <= int'(NR); r++) begin
            logic [127:0] d;
            d = {$urandom, $urandom, $urandom, $urandom};
            drive_b(d, d ^ keys[r], 4'(r));
        end
        waited = 0;
        while (!done_b && waited < 10) begin
            tick();
            waited++;
        end
        check("done_w128", 160'({done_b, busy_b}), 160'(2'b10));
        check("sb_drained_w128", 160'(sb_b.size()), 160'(0));

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
